// File: rtl/reg_lane_streamer.sv
// reg_lane_streamer: snapshots one register (or the reg3/reg4 pair) and streams it lane by lane; define STREAM_PARITY_EN to add out_parity
module reg_lane_streamer #(
  parameter int LANES = 16,
  parameter int LANE_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [LANES*LANE_W-1:0]  reg1,
  input  logic [LANES*LANE_W-1:0]  reg2,
  input  logic [LANES*LANE_W-1:0]  reg3,
  input  logic [LANES*LANE_W-1:0]  reg4,
  input  logic                     start,
  input  logic [1:0]               rd_addr,
  input  logic                     rd_pair,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_data,
  output logic [3:0]               out_index,
  output logic                     out_last,
  output logic                     done
`ifdef STREAM_PARITY_EN
  ,
  output logic                     out_parity
`endif
);
  localparam int W = LANES * LANE_W;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  state_t state;
  logic [W-1:0] snap_a, snap_b, cap_a, cap_b;
  logic pair;
  logic [3:0] nxt;
  // Pair beats rebuild {reg4 lane, reg3 lane}; single-register beats are sign-extended lanes
  function automatic logic [63:0] beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic p, input logic [3:0] i);
    logic [LANE_W-1:0] la, lb;
    la = a[int'(i)*LANE_W +: LANE_W];
    lb = b[int'(i)*LANE_W +: LANE_W];
    return p ? {lb, la} : {{(64-LANE_W){la[LANE_W-1]}}, la};
  endfunction
  // Register selection presented to the capture edge
  always_comb begin
    cap_a = rd_pair ? reg3 : rd_addr == 2'd0 ? reg1 : rd_addr == 2'd1 ? reg2 : rd_addr == 2'd2 ? reg3 : reg4;
    cap_b = rd_pair ? reg4 : '0;
    nxt = out_index + 4'd1;
  end
  // Capture, lane-by-lane handshake and one-cycle done pulse; out_index doubles as the lane counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      snap_a <= '0;
      snap_b <= '0;
      pair <= 1'b0;
      busy <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_index <= '0;
      out_last <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= STREAM;
          snap_a <= cap_a;
          snap_b <= cap_b;
          pair <= rd_pair;
          busy <= 1'b1;
          out_valid <= 1'b1;
          out_data <= beat(cap_a, cap_b, rd_pair, 4'd0);
          out_index <= '0;
          out_last <= LANES == 1;
        end
        STREAM: if (out_ready) begin
          if (out_last) begin
            state <= DONE;
            out_valid <= 1'b0;
            out_data <= '0;
            out_index <= '0;
            out_last <= 1'b0;
            done <= 1'b1;
          end else begin
            out_data <= beat(snap_a, snap_b, pair, nxt);
            out_index <= nxt;
            out_last <= nxt == 4'(LANES - 1);
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef STREAM_PARITY_EN
  assign out_parity = ^out_data;
`endif
endmodule
